// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the FIFO serial transmitter.
// Holds the FSM state enum, counter width and a saturating increment.
package fifo_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  localparam int UNDERRUN_CNT_W = 16;
  localparam int MIN_CLK_DIV    = 2;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
    input logic [UNDERRUN_CNT_W-1:0] v
  );
    return (&v) ? v : v + UNDERRUN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_serial_tx_bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV, strobes on each toggle.
// Ports: i_clk, i_rst, i_clr (sync clear), o_bclk, o_rise_stb, o_fall_stb.
module fifo_serial_tx_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_bclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_div_cnt;
  logic          r_bclk;
  logic          w_tick;

  assign w_tick = !i_clr &&
                  (r_div_cnt == CW'(CLK_DIV - 1));

  // Strobes fire in the cycle whose edge performs the toggle.
  assign o_rise_stb = w_tick && !r_bclk;
  assign o_fall_stb = w_tick && r_bclk;
  assign o_bclk     = r_bclk;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO drain stage: pops words and shifts them out as left-justified stereo.
// Ports: clk, rst, enable_i, fifo_* read port, bclk/lrclk/sdata, underrun flags.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic [DATA_WIDTH-1:0]     fifo_data_i,
  input  logic                      fifo_empty_i,
  output logic                      fifo_rd_en_o,
  output logic                      bclk_o,
  output logic                      lrclk_o,
  output logic                      sdata_o,
  output logic                      underrun_o,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
);

  if (CLK_DIV < MIN_CLK_DIV) begin : g_clk_div_chk
    $error("fifo_serial_tx: CLK_DIV must be >= %0d", MIN_CLK_DIV);
  end

  localparam int BW = $clog2(DATA_WIDTH);

  state_t                    r_state;
  state_t                    w_state_nx;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [BW-1:0]             r_bit_cnt;
  logic                      r_lrclk;
  logic                      r_underrun;
  logic [UNDERRUN_CNT_W-1:0] r_ur_cnt;
  logic [DATA_WIDTH-1:0]     r_next_word;
  logic                      r_next_valid;
  logic                      r_pend;
  logic                      r_rst_q;

  logic w_pop;
  logic w_clr;
  logic w_fall;
  logic w_rise_unused;
  logic w_load;
  logic w_stop;
  logic w_rd_en;

  fifo_serial_tx_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (w_clr),
    .o_bclk     (bclk_o),
    .o_rise_stb (w_rise_unused),
    .o_fall_stb (w_fall)
  );

  assign w_load = (r_state == RUN) && w_fall &&
                  (r_bit_cnt == BW'(DATA_WIDTH - 1));
  // Stop only at the end of a right slot so pairs stay intact.
  assign w_stop = !enable_i && r_lrclk;

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_clr      = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (enable_i && !fifo_empty_i && !r_rst_q) begin
          w_pop      = 1'b1;
          w_state_nx = PRIME;
        end
      end
      PRIME: begin
        w_state_nx = RUN;
      end
      RUN: begin
        w_clr = 1'b0;
        if (enable_i && !r_next_valid && !r_pend &&
            !fifo_empty_i) begin
          w_pop = 1'b1;
        end
        if (w_load && w_stop) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // No pop while reset is asserted or in the cycle right after it.
  assign w_rd_en      = w_pop && !rst && !r_rst_q;
  assign fifo_rd_en_o = w_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_lrclk      <= 1'b0;
      r_underrun   <= 1'b0;
      r_ur_cnt     <= '0;
      r_next_word  <= '0;
      r_next_valid <= 1'b0;
      r_pend       <= 1'b0;
      r_rst_q      <= 1'b1;
    end else begin
      r_rst_q    <= 1'b0;
      r_state    <= w_state_nx;
      r_underrun <= 1'b0;

      if (r_state == PRIME) begin
        r_shift   <= fifo_data_i;
        r_bit_cnt <= '0;
        r_lrclk   <= 1'b0;
      end else if (w_load) begin
        r_bit_cnt <= '0;
        if (w_stop) begin
          r_shift <= '0;
          r_lrclk <= 1'b0;
        end else begin
          r_lrclk <= ~r_lrclk;
          if (r_next_valid) begin
            r_shift <= r_next_word;
          end else begin
            r_shift    <= '0;
            r_underrun <= 1'b1;
            r_ur_cnt   <= sat_inc(r_ur_cnt);
          end
        end
      end else if ((r_state == RUN) && w_fall) begin
        r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end

      // A capture landing on a load event wins: the slot
      // underruns and the word is kept for the next slot.
      if (r_pend) begin
        r_next_word  <= fifo_data_i;
        r_next_valid <= 1'b1;
        r_pend       <= 1'b0;
      end else if (w_load) begin
        r_next_valid <= 1'b0;
      end

      if (w_rd_en && (r_state == RUN)) begin
        r_pend <= 1'b1;
      end

      if (w_load && w_stop) begin
        r_next_valid <= 1'b0;
        r_pend       <= 1'b0;
      end
    end
  end

  assign lrclk_o        = r_lrclk;
  assign sdata_o        = r_shift[DATA_WIDTH-1];
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_ur_cnt;

endmodule
